// File: rtl/dvs_ravens_pkg.sv
// Shared types and constants for the DVS / RAVENS front end.
// Event bundle, receiver states and the timebase constants.
package dvs_ravens_pkg;

  localparam int DVS_AER_BITS      = 10;
  localparam int DVS_X_ADDR_BITS   = 9;
  localparam int DVS_Y_ADDR_BITS   = 9;
  localparam int TIMESTAMP_US_BITS = 32;
  localparam int CLK_PERIOD_NS     = 10;
  localparam int DVS_Y_SETUP_NS    = 50;
  localparam int US_CYCLES         = 1000 / CLK_PERIOD_NS;

  typedef struct packed {
    logic [DVS_X_ADDR_BITS-1:0]   x;
    logic [DVS_Y_ADDR_BITS-1:0]   y;
    logic                         polarity;
    logic [TIMESTAMP_US_BITS-1:0] timestamp;
  } aer_event_t;

  typedef enum logic [1:0] {
    IDLE,
    Y_SETUP,
    X_CAP,
    ACK_HI
  } aer_rx_state_t;

  function automatic int ceil_div(input int a, input int b);
    return (a + b - 1) / b;
  endfunction

endpackage

// File: rtl/dvs_event_fifo.sv
// Show-ahead synchronous FIFO for rebuilt DVS events.
// Head is visible while non-empty; head reads as zero when empty.
module dvs_event_fifo
  import dvs_ravens_pkg::*;
#(
  parameter int  DEPTH = 4,
  parameter type T     = aer_event_t
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push_i,
  input  T                       data_i,
  input  logic                   pop_i,
  output T                       data_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  T               mem_q [DEPTH];
  logic [AW-1:0]  wr_q;
  logic [AW-1:0]  rd_q;
  logic [CW-1:0]  cnt_q;
  logic [CW-1:0]  cnt_d;
  logic           push_ok;
  logic           pop_ok;

  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;
  assign data_o  = empty_o ? '0 : mem_q[rd_q];

  // Occupancy next-state from the accepted push/pop pair.
  always_comb begin
    cnt_d = cnt_q;
    unique case (1'b1)
      push_ok && !pop_ok: cnt_d = cnt_q + CW'(1);
      pop_ok && !push_ok: cnt_d = cnt_q - CW'(1);
      default:            cnt_d = cnt_q;
    endcase
  end

  // Storage write; contents are don't-care until counted.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_q] <= data_i;
  end

  // Pointers and occupancy; reset empties the queue.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push_ok) wr_q <= wr_q + AW'(1);
      if (pop_ok)  rd_q <= rd_q + AW'(1);
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/dvs_aer_stream_receiver.sv
// DVS AER receiver: 4-phase handshake, Y setup, µs timestamps,
// and event FIFO with valid/ready output and overflow policy.
module dvs_aer_stream_receiver
  import dvs_ravens_pkg::*;
#(
  parameter int AER_BITS      = DVS_AER_BITS,
  parameter int X_BITS        = DVS_X_ADDR_BITS,
  parameter int Y_BITS        = DVS_Y_ADDR_BITS,
  parameter int TS_BITS       = TIMESTAMP_US_BITS,
  parameter int CLK_PERIOD_NS = dvs_ravens_pkg::CLK_PERIOD_NS,
  parameter int Y_SETUP_NS    = DVS_Y_SETUP_NS,
  parameter int FIFO_DEPTH    = 4,
  parameter bit DROP_ON_FULL  = 1'b1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [AER_BITS-1:0] aer,
  input  logic                xsel,
  input  logic                req,
  output logic                ack,
  output logic [X_BITS-1:0]   event_x,
  output logic [Y_BITS-1:0]   event_y,
  output logic [TS_BITS-1:0]  event_timestamp,
  output logic                event_polarity,
  output logic                event_valid,
  input  logic                event_ready,
  output logic                overflow,
  output logic                proto_err,
  output logic [15:0]         drop_count
);

  localparam int US_CYC = 1000 / CLK_PERIOD_NS;
  localparam int Y_CYC  = ceil_div(Y_SETUP_NS, CLK_PERIOD_NS);

  typedef struct packed {
    logic [X_BITS-1:0]  x;
    logic [Y_BITS-1:0]  y;
    logic               polarity;
    logic [TS_BITS-1:0] timestamp;
  } ev_t;

  aer_rx_state_t        state_q;
  logic                 req_m_q;
  logic                 req_s_q;
  logic                 ack_q;
  logic [15:0]          cnt_q;
  logic [Y_BITS-1:0]    row_y_q;
  logic                 row_valid_q;
  logic                 y_stamped_q;
  logic [TS_BITS-1:0]   ts_pend_q;
  logic                 ovf_q;
  logic                 perr_q;
  logic [15:0]          drop_q;
  logic [15:0]          pre_q;
  logic [15:0]          pre_d;
  logic [TS_BITS-1:0]   ts_q;
  logic [TS_BITS-1:0]   ts_d;

  ev_t                  push_ev;
  ev_t                  head_ev;
  logic                 push;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic [$clog2(FIFO_DEPTH):0] unused_cnt;

  assign push = (state_q == X_CAP) && row_valid_q && !fifo_full;

  assign push_ev.x         = aer[X_BITS:1];
  assign push_ev.y         = row_y_q;
  assign push_ev.polarity  = aer[0];
  assign push_ev.timestamp = ts_pend_q;

  dvs_event_fifo #(
    .DEPTH (FIFO_DEPTH),
    .T     (ev_t)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .data_i  (push_ev),
    .pop_i   (event_ready),
    .data_o  (head_ev),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (unused_cnt)
  );

  assign ack             = ack_q;
  assign overflow        = ovf_q;
  assign proto_err       = perr_q;
  assign drop_count      = drop_q;
  assign event_valid     = !fifo_empty;
  assign event_x         = head_ev.x;
  assign event_y         = head_ev.y;
  assign event_polarity  = head_ev.polarity;
  assign event_timestamp = head_ev.timestamp;

  // Microsecond prescaler and wrapping timestamp next-state.
  always_comb begin
    pre_d = pre_q + 16'd1;
    ts_d  = ts_q;
    if (pre_q == 16'(US_CYC - 1)) begin
      pre_d = '0;
      ts_d  = ts_q + TS_BITS'(1);
    end
  end

  // Timebase registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pre_q <= '0;
      ts_q  <= '0;
    end else begin
      pre_q <= pre_d;
      ts_q  <= ts_d;
    end
  end

  // Two-flop synchronizer for the camera request.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      req_m_q <= 1'b0;
      req_s_q <= 1'b0;
    end else begin
      req_m_q <= req;
      req_s_q <= req_m_q;
    end
  end

  // Handshake FSM with registered ack and sticky status.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ack_q       <= 1'b0;
      cnt_q       <= '0;
      row_y_q     <= '0;
      row_valid_q <= 1'b0;
      y_stamped_q <= 1'b0;
      ts_pend_q   <= '0;
      ovf_q       <= 1'b0;
      perr_q      <= 1'b0;
      drop_q      <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          ack_q <= 1'b0;
          if (req_s_q && !xsel) begin
            state_q     <= Y_SETUP;
            cnt_q       <= 16'(Y_CYC);
            ts_pend_q   <= ts_q;
            y_stamped_q <= 1'b1;
          end else if (req_s_q) begin
            state_q <= X_CAP;
            if (!y_stamped_q) ts_pend_q <= ts_q;
          end
        end
        Y_SETUP: begin
          if (cnt_q <= 16'd1) begin
            row_y_q     <= aer[Y_BITS-1:0];
            row_valid_q <= 1'b1;
            ack_q       <= 1'b1;
            state_q     <= ACK_HI;
          end else begin
            cnt_q <= cnt_q - 16'd1;
          end
        end
        X_CAP: begin
          if (!row_valid_q) begin
            perr_q      <= 1'b1;
            ack_q       <= 1'b1;
            y_stamped_q <= 1'b0;
            state_q     <= ACK_HI;
          end else if (!fifo_full) begin
            ack_q       <= 1'b1;
            y_stamped_q <= 1'b0;
            state_q     <= ACK_HI;
          end else if (DROP_ON_FULL) begin
            ovf_q       <= 1'b1;
            if (drop_q != 16'hFFFF) drop_q <= drop_q + 16'd1;
            ack_q       <= 1'b1;
            y_stamped_q <= 1'b0;
            state_q     <= ACK_HI;
          end else begin
            ack_q <= 1'b0;
          end
        end
        ACK_HI: begin
          if (!req_s_q) begin
            ack_q   <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dvs_aer_stream_receiver.sv
// Bench for dvs_aer_stream_receiver: camera driver, queue model,
// per-cycle compare, plus drop-mode and stall-mode scenarios.
module tb_dvs_aer_stream_receiver;
  import dvs_ravens_pkg::*;

  logic        clk = 0;
  logic        rst_n = 0;
  logic [9:0]  aer = '0;
  logic        xsel = 0;
  logic        req_a = 0;
  logic        req_b = 0;
  logic        dir_rdy_a = 0;
  logic        dir_rdy_b = 0;
  logic        rnd_rdy = 0;
  logic        rand_on = 0;
  logic        rdy_a;
  logic        rdy_b;

  logic        ack_a, ack_b;
  logic [8:0]  x_a, x_b, y_a, y_b;
  logic [31:0] ts_a, ts_b;
  logic        pol_a, pol_b, val_a, val_b;
  logic        ovf_a, ovf_b, perr_a, perr_b;
  logic [15:0] drop_a, drop_b;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int t_req = 0;
  int t0 = 0;
  bit cur_x = 0;
  logic [9:0] cur_a = '0;

  typedef struct {
    int     x;
    int     y;
    int     p;
    longint ts;
  } mev_t;

  mev_t        mq[$];
  int          pre_sz = 0;
  bit          prev_ack = 0;
  bit          m_rv = 0;
  bit          m_ys = 0;
  int          m_row = 0;
  longint      m_pend = 0;
  bit          m_ovf = 0;
  bit          m_perr = 0;
  int          m_drops = 0;

  assign rdy_a = rand_on ? rnd_rdy : dir_rdy_a;
  assign rdy_b = dir_rdy_b;

  dvs_aer_stream_receiver #(.FIFO_DEPTH(4), .DROP_ON_FULL(1'b1)) u_a (
    .clk(clk), .rst_n(rst_n), .aer(aer), .xsel(xsel), .req(req_a),
    .ack(ack_a), .event_x(x_a), .event_y(y_a), .event_timestamp(ts_a),
    .event_polarity(pol_a), .event_valid(val_a), .event_ready(rdy_a),
    .overflow(ovf_a), .proto_err(perr_a), .drop_count(drop_a));

  dvs_aer_stream_receiver #(.FIFO_DEPTH(4), .DROP_ON_FULL(1'b0)) u_b (
    .clk(clk), .rst_n(rst_n), .aer(aer), .xsel(xsel), .req(req_b),
    .ack(ack_b), .event_x(x_b), .event_y(y_b), .event_timestamp(ts_b),
    .event_polarity(pol_b), .event_valid(val_b), .event_ready(rdy_b),
    .overflow(ovf_b), .proto_err(perr_b), .drop_count(drop_b));

  initial forever #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial forever begin
    @(posedge clk);
    #2 rnd_rdy = 1'($urandom_range(0, 1));
  end

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic bit ack_of(input bit d);
    return d ? ack_b : ack_a;
  endfunction

  // Reference: queue of expected events, decided at each ack rise.
  always @(negedge clk) begin
    if (!rst_n) begin
      mq.delete();
      pre_sz = 0; prev_ack = 0; m_rv = 0; m_ys = 0;
      m_ovf = 0; m_perr = 0; m_drops = 0;
    end else begin
      if (ack_a && !prev_ack) begin
        if (!cur_x) begin
          m_row = int'(cur_a[8:0]);
          m_rv = 1;
          m_pend = longint'((t_req - t0) / 100);
          m_ys = 1;
        end else begin
          if (!m_ys) m_pend = longint'((t_req - t0) / 100);
          m_ys = 0;
          if (!m_rv) m_perr = 1;
          else if (pre_sz < 4)
            mq.push_back('{x: int'(cur_a[9:1]), y: m_row,
                           p: int'(cur_a[0]), ts: m_pend});
          else begin
            m_ovf = 1;
            if (m_drops != 65535) m_drops++;
          end
        end
      end
      prev_ack = ack_a;
      chk("valid", val_a, mq.size() > 0);
      chk("overflow", ovf_a, m_ovf);
      chk("proto_err", perr_a, m_perr);
      chk("drop_count", drop_a, m_drops);
      if (mq.size() > 0 && val_a) begin
        longint d;
        chk("head_x", x_a, mq[0].x);
        chk("head_y", y_a, mq[0].y);
        chk("head_pol", pol_a, mq[0].p);
        d = longint'(ts_a) - mq[0].ts;
        checks++;
        if (d < -1 || d > 1) begin
          errors++;
          $display("FAIL head_ts got %0d want %0d+-1", ts_a, mq[0].ts);
        end
      end
      pre_sz = mq.size();
      if (val_a && rdy_a && mq.size() > 0) void'(mq.pop_front());
    end
  end

  // One camera handshake on receiver d (0 = drop mode, 1 = stall mode).
  task automatic hs(input bit d, input bit xs, input logic [9:0] a,
                    input bit lat);
    int n;
    bit ok;
    aer = a; xsel = xs;
    if (!d) begin cur_x = xs; cur_a = a; end
    @(posedge clk); #2;
    if (d) req_b = 1;
    else begin t_req = cyc; req_a = 1; end
    n = 0; ok = 0;
    while (n < 200 && !ok) begin
      @(posedge clk); #1; n++;
      if (ack_of(d)) ok = 1;
    end
    if (!ok) chk("ack_timeout", 0, 1);
    else if (lat) chk(xs ? "x_latency" : "y_latency", n, xs ? 4 : 8);
    #1;
    if (d) req_b = 0; else req_a = 0;
    n = 0;
    while (n < 50 && ack_of(d)) begin
      @(posedge clk); #1; n++;
    end
    if (ack_of(d)) chk("ack_fall_timeout", 1, 0);
    else if (lat) chk("ack_fall", n, 3);
  endtask

  initial begin
    int n;
    bit seen;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ack", ack_a, 0);
    chk("rst_valid", val_a, 0);
    chk("rst_ovf", ovf_a, 0);
    chk("rst_perr", perr_a, 0);
    chk("rst_drop", drop_a, 0);
    chk("rst_x", x_a, 0);
    chk("rst_ts", ts_a, 0);
    chk("rst_ack_b", ack_b, 0);
    #1 rst_n = 1; t0 = cyc;

    dir_rdy_a = 1;
    hs(0, 1, 10'h155, 1);
    chk("x_first_perr", perr_a, 1);
    chk("x_first_valid", val_a, 0);

    dir_rdy_a = 0;
    hs(0, 0, 10'h0A5, 1);
    hs(0, 1, 10'h25F, 1);
    @(negedge clk);
    chk("ev_x", x_a, 9'h12F);
    chk("ev_y", y_a, 9'h0A5);
    chk("ev_pol", pol_a, 1);
    chk("ev_valid", val_a, 1);
    dir_rdy_a = 1;
    repeat (5) @(posedge clk);
    #2 dir_rdy_a = 0;

    hs(0, 0, 10'h010, 1);
    hs(0, 1, 10'h002, 1);
    repeat (300) @(posedge clk);
    hs(0, 1, 10'h004, 1);
    repeat (300) @(posedge clk);
    hs(0, 1, 10'h006, 1);
    hs(0, 1, 10'h008, 1);
    hs(0, 1, 10'h00A, 1);
    hs(0, 1, 10'h00C, 1);
    @(negedge clk);
    chk("drops_two", drop_a, 2);
    chk("ovf_set", ovf_a, 1);
    chk("row_head_x", x_a, 1);
    chk("row_head_y", y_a, 9'h010);
    dir_rdy_a = 1;
    repeat (10) @(posedge clk);

    rand_on = 1;
    repeat (60) begin
      hs(0, ($urandom_range(0, 9) >= 3), 10'($urandom), 1);
      repeat ($urandom_range(0, 4)) @(posedge clk);
    end
    rand_on = 0;
    repeat (10) @(posedge clk);

    dir_rdy_a = 0;
    hs(0, 0, 10'h033, 1);
    hs(0, 1, 10'h0F1, 1);
    aer = 10'h0F3; xsel = 1; cur_x = 1; cur_a = 10'h0F3;
    @(posedge clk); #2 t_req = cyc; req_a = 1;
    n = 0;
    while (n < 50 && !ack_a) begin
      @(posedge clk); #1; n++;
    end
    chk("pre_rst_ack", ack_a, 1);
    #1 rst_n = 0;
    @(posedge clk); #1;
    chk("mid_rst_ack", ack_a, 0);
    chk("mid_rst_valid", val_a, 0);
    chk("mid_rst_drop", drop_a, 0);
    chk("mid_rst_ovf", ovf_a, 0);
    chk("mid_rst_perr", perr_a, 0);
    #1 rst_n = 1; t0 = cyc; t_req = cyc;
    n = 0;
    while (n < 50 && !ack_a) begin
      @(posedge clk); #1; n++;
    end
    chk("rerequest_ack", ack_a, 1);
    #1 req_a = 0;
    n = 0;
    while (n < 50 && ack_a) begin
      @(posedge clk); #1; n++;
    end
    chk("rerequest_ack_fall", ack_a, 0);
    chk("rerequest_perr", perr_a, 1);
    chk("rerequest_valid", val_a, 0);

    dir_rdy_b = 0;
    hs(1, 0, 10'h010, 0);
    for (int i = 1; i <= 4; i++) hs(1, 1, 10'(i * 2), 0);
    aer = 10'h00A; xsel = 1;
    @(posedge clk); #2 req_b = 1;
    seen = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (ack_b) seen = 1;
    end
    chk("stall_ack_low", seen, 0);
    chk("stall_valid", val_b, 1);
    #1 dir_rdy_b = 1;
    @(posedge clk); #2 dir_rdy_b = 0;
    n = 1;
    while (n < 10 && !ack_b) begin
      @(posedge clk); #1; n++;
    end
    chk("stall_release", (ack_b && n <= 2), 1);
    #1 req_b = 0;
    n = 0;
    while (n < 50 && ack_b) begin
      @(posedge clk); #1; n++;
    end
    chk("stall_ack_fall", ack_b, 0);
    chk("stall_drops", drop_b, 0);
    chk("stall_ovf", ovf_b, 0);
    chk("stall_head_x", x_b, 2);
    #1 dir_rdy_b = 1;
    repeat (6) @(posedge clk);
    #1 chk("stall_drained", val_b, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dvs_aer_stream_receiver.md
# dvs_aer_stream_receiver

Parametrised, next-generation DVS AER receiver. Performs the sender-driven 4-phase REQ/ACK handshake with the DVS camera and enforces a configurable Y-address setup time. It timestamps each event in microseconds and rebuilds full (x, y, polarity, timestamp) events into an output FIFO with a valid/ready interface. It sits between the camera pins and the RAVENS spike-encoding logic, and adds two things the first receiver lacks: downstream backpressure and an overflow policy.

## Interface
- AER_BITS, 10, AER bus width
- X_BITS, DVS_X_ADDR_BITS, X address width
- Y_BITS, DVS_Y_ADDR_BITS, Y address width
- TS_BITS, TIMESTAMP_US_BITS, timestamp width (µs)
- CLK_PERIOD_NS, CLK_PERIOD_NS, clock period; 1000 must be divisible by it
- Y_SETUP_NS, 50, minimum REQ-to-ACK time for Y addresses
- FIFO_DEPTH, 4, output event FIFO depth (power of 2, ≥2)
- DROP_ON_FULL, 1, 1 = drop X events when FIFO full; 0 = stall ACK until space
- clk  in  1  system clock; one clock domain
- rst_n  in  1  reset, synchronous, active-low
- aer  in  AER_BITS  AER data; Y: aer[Y_BITS-1:0]=Y, MSB ignored; X: aer[AER_BITS-1:1]=X, aer[0]=polarity
- xsel  in  1  0 = Y address, 1 = X address
- req  in  1  asynchronous request from camera
- ack  out  1  acknowledge to camera
- event_x  out  X_BITS  FIFO head X
- event_y  out  Y_BITS  FIFO head Y
- event_timestamp  out  TS_BITS  FIFO head timestamp (µs)
- event_polarity  out  1  FIFO head polarity
- event_valid  out  1  FIFO non-empty
- event_ready  in  1  consumer pops head when valid & ready
- overflow  out  1  sticky: an event was dropped on a full FIFO
- proto_err  out  1  sticky: X received with no valid Y since reset
- drop_count  out  16  saturating count of dropped events

## Operation
- req passes a 2-flop synchronizer (req_s). aer and xsel are sampled directly; they are bundled data, stable while req is high.
- µs timebase: a prescaler counts US_CYCLES = 1000/CLK_PERIOD_NS cycles and increments a free-running TS_BITS counter, which wraps modulo 2^TS_BITS.
- Timestamp on entry to IDLE->capture:
  - Y request: latch ts_pend and set y_stamped.
  - X request: latch ts_pend only if y_stamped=0.
  - Every X handshake clears y_stamped.
- FSM states:
  - IDLE: ack=0. If req_s=1 and xsel=0, go to Y_SETUP and load the counter with ceil(Y_SETUP_NS/CLK_PERIOD_NS). If req_s=1 and xsel=1, go to X_CAP.
  - Y_SETUP: decrement the counter. At zero, store row_y and set row_valid, assert ack, go to ACK_HI.
  - X_CAP:
    - If row_valid=0: set proto_err, assert ack, no push.
    - Else if the FIFO has space: push {x, row_y, pol, ts_pend}, assert ack.
    - Else if DROP_ON_FULL=1: drop, set overflow, increment drop_count, assert ack.
    - Else: stay in X_CAP with ack=0 until space is available.
    - Leaving X_CAP goes to ACK_HI.
  - ACK_HI: ack=1 until req_s=0, then ack=0 and go to IDLE.
- row_y persists across consecutive X events (multiple X per row).
- A simultaneous FIFO push and pop when full is not allowed: "full" is evaluated before the pop. A push and pop when not full are both performed.

## Timing
- Reset values: ack=0, event_valid=0, overflow=0, proto_err=0, drop_count=0, row_valid=0, y_stamped=0, timestamp counter=0, prescaler=0, state=IDLE, FIFO empty. event_x/y/timestamp/polarity are 0.
- REQ-to-ACK:
  - X: 2 sync cycles + 1 IDLE cycle + 1 X_CAP cycle.
  - Y: 2 + 1 + ceil(Y_SETUP_NS/CLK_PERIOD_NS) cycles, always ≥ Y_SETUP_NS.
- ack falls 3 cycles after req falls (2 sync + 1 registered).
- event_valid rises on the edge after the X push, which is the same edge on which ack is already high.
- Timestamp accuracy: within ±1 µs of the REQ rise of the event's first handshake.
- rst_n low mid-handshake: ack drops on the next edge, the FIFO is flushed, and a half-received event is discarded. The camera's still-high req is then treated as a new request once reset is released.

## Structure
- The dvs_ravens_pkg package gains:
  - aer_event_t packed struct {x, y, polarity, timestamp}
  - aer_rx_state_t enum {IDLE, Y_SETUP, X_CAP, ACK_HI}
  - DVS_Y_SETUP_NS = 50
  - US_CYCLES
- One sub-module: dvs_event_fifo, a parametrised synchronous show-ahead FIFO of aer_event_t with full, empty and count outputs.

## Test plan
Conditions: CLK_PERIOD_NS=10, FIFO_DEPTH=4, event_ready=1 unless stated.
- Y=0x0A5 then X=0x12F, pol=1 -> ack for Y rises ≥50 ns after req; event {x=0x12F, y=0x0A5, pol=1} valid; timestamp within ±1 of the Y req time in µs.
- Y=0x010, then three X events 0x001/0x002/0x003 -> three events all with y=0x010; the 2nd and 3rd carry their own X-req timestamps.
- event_ready=0, DROP_ON_FULL=1, 6 X events after one Y -> FIFO holds the first 4; overflow=1; drop_count=2; ack never stalls.
- DROP_ON_FULL=0, event_ready=0, 5th X event -> ack stays 0 until one pop, then rises within 2 cycles; no drops.
- X event straight after reset -> proto_err=1, no event_valid, handshake still completes.
- rst_n asserted for 1 cycle while in ACK_HI with 2 events queued -> ack=0 and event_valid=0 on the next edge; counters are cleared.
